// File: rtl/ahb_mem_pkg.sv
// ahb_mem_pkg: shared AHB-Lite encodings and byte-strobe helper for ahb_mem_ws
package ahb_mem_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'd0, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ} htrans_e;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF, HSIZE_WORD, HSIZE_DWORD,
                            HSIZE_4W, HSIZE_8W, HSIZE_16W, HSIZE_32W} hsize_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_e;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam int MaxBytes = 8;
  function automatic logic [MaxBytes-1:0] byte_enable(input logic [2:0] hsize,
                                                      input logic [2:0] addr_lsbs,
                                                      input logic [3:0] bytes);
    logic [15:0] span;
    span = (16'd1 << (5'd1 << hsize)) - 16'd1;
    return MaxBytes'(span << (addr_lsbs & 3'(bytes - 4'd1)));
  endfunction
endpackage

// File: rtl/ahb_mem_array.sv
// ahb_mem_array: word storage with per-byte write enables and an asynchronous read port
module ahb_mem_array import ahb_mem_pkg::*; #(
  parameter int DataWidth = 32,
  parameter int DepthWords = 1024,
  localparam int Bytes = DataWidth / 8,
  localparam int IdxW = $clog2(DepthWords)
) (
  input  logic                 clk,
  input  logic [Bytes-1:0]     we,
  input  logic [IdxW-1:0]      idx,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);
  logic [DataWidth-1:0] mem [DepthWords];
  always_ff @(posedge clk)
    for (int b = 0; b < Bytes; b++)
      if (we[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/ahb_mem_ws.sv
// ahb_mem_ws: parametrised AHB-Lite subordinate memory with wait states,
// sub-word writes and a two-cycle ERROR response for illegal accesses
module ahb_mem_ws import ahb_mem_pkg::*; #(
  parameter int AddressWidth = 32,
  parameter int DataWidth = 32,
  parameter int DepthWords = 1024,
  parameter logic [AddressWidth-1:0] BaseAddress = '0,
  parameter int WaitStates = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hsel,
  input  logic [AddressWidth-1:0] haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [DataWidth-1:0]    hwdata,
  input  logic                    hready,
  output logic [DataWidth-1:0]    hrdata,
  output logic                    hreadyout,
  output logic                    hresp
);
  localparam int Bytes = DataWidth / 8;
  localparam int ByteBits = $clog2(Bytes);
  localparam int IdxW = $clog2(DepthWords);
  localparam logic [63:0] Span = 64'(DepthWords) * 64'(Bytes);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [Bytes-1:0] be_q, be_d, we;
  logic write_q, write_d, hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic [AddressWidth-1:0] offset;
  logic [MaxBytes-1:0] be_full;
  logic [DataWidth-1:0] rdata;
  logic accept, illegal, complete, open, unused_hburst;
  assign unused_hburst = ^hburst;
  assign offset = haddr - BaseAddress;
  assign accept = hsel && hready && htrans[1];
  assign illegal = 64'(haddr) < 64'(BaseAddress) || 64'(haddr) >= 64'(BaseAddress) + Span ||
                   hsize > 3'(ByteBits) || |(haddr[2:0] & 3'((4'd1 << hsize) - 4'd1));
  assign complete = state_q == ST_ACCESS && cnt_q == '0;
  assign open = state_q == ST_IDLE || state_q == ST_ERR2 || complete;
  assign be_full = byte_enable(hsize, 3'(haddr[ByteBits-1:0]), 4'(Bytes));
  always_comb begin
    state_d = state_q == ST_ERR1 ? ST_ERR2 :
              (state_q == ST_ACCESS && !complete) ? ST_ACCESS : ST_IDLE;
    cnt_d = (state_q == ST_ACCESS && cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
    idx_d = idx_q;
    be_d = be_q;
    write_d = write_q;
    if (open && accept) begin
      state_d = illegal ? ST_ERR1 : ST_ACCESS;
      cnt_d = 4'(WaitStates);
      idx_d = IdxW'(offset >> ByteBits);
      be_d = Bytes'(be_full);
      write_d = hwrite && !illegal;
    end
    hreadyout_d = state_d == ST_ACCESS ? cnt_d == '0 : state_d != ST_ERR1;
    hresp_d = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      be_q <= '0;
      write_q <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      be_q <= be_d;
      write_q <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q <= hresp_d;
    end
  end
  // a reset landing on the completing edge must not let the write through
  assign we = (complete && write_q && !rst) ? be_q : '0;
  ahb_mem_array #(.DataWidth(DataWidth), .DepthWords(DepthWords)) u_array (
    .clk(clk), .we(we), .idx(idx_q), .wdata(hwdata), .rdata(rdata)
  );
  assign hrdata = state_q == ST_ACCESS ? rdata : '0;
  assign hreadyout = hreadyout_q;
  assign hresp = hresp_q;
endmodule

// File: tb/tb_ahb_mem_ws.sv
// tb_ahb_mem_ws: directed scoreboard bench over four differently configured ahb_mem_ws instances
module tb_ahb_mem_ws;
  typedef struct {logic wr; logic [31:0] addr; logic [2:0] size; logic [63:0] wdata;} xfer_t;
  typedef struct {string tag; int waits; logic resp; logic rdchk; logic [63:0] rdata;} exp_t;
  logic clk = 0, rst = 1, sel = 0, hwrite = 0, hready;
  logic [31:0] haddr = 0;
  logic [1:0] htrans = 0, cur = 0;
  logic [2:0] hsize = 0;
  logic [63:0] hw = 0, rd_cur;
  logic [3:0] hsel_v, ro, rs;
  logic [31:0] rd0, rd1, rd3;
  logic [63:0] rd2;
  int ncmp = 0, nfail = 0;
  xfer_t pend[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  assign hsel_v = sel ? 4'b1 << cur : 4'b0;
  assign hready = ro[cur];
  assign rd_cur = cur == 2'd0 ? 64'(rd0) : cur == 2'd1 ? 64'(rd1) : cur == 2'd2 ? rd2 : 64'(rd3);

  ahb_mem_ws #(.DataWidth(32), .DepthWords(1024), .BaseAddress(32'h0), .WaitStates(0)) d0 (
    .clk(clk), .rst(rst), .hsel(hsel_v[0]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hwdata(hw[31:0]), .hready(hready), .hrdata(rd0),
    .hreadyout(ro[0]), .hresp(rs[0]));
  ahb_mem_ws #(.DataWidth(32), .DepthWords(1024), .BaseAddress(32'h1000), .WaitStates(3)) d1 (
    .clk(clk), .rst(rst), .hsel(hsel_v[1]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hwdata(hw[31:0]), .hready(hready), .hrdata(rd1),
    .hreadyout(ro[1]), .hresp(rs[1]));
  ahb_mem_ws #(.DataWidth(64), .DepthWords(256), .BaseAddress(32'h0), .WaitStates(0)) d2 (
    .clk(clk), .rst(rst), .hsel(hsel_v[2]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hwdata(hw), .hready(hready), .hrdata(rd2),
    .hreadyout(ro[2]), .hresp(rs[2]));
  ahb_mem_ws #(.DataWidth(32), .DepthWords(64), .BaseAddress(32'h0), .WaitStates(2)) d3 (
    .clk(clk), .rst(rst), .hsel(hsel_v[3]), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'd0), .hwdata(hw[31:0]), .hready(hready), .hrdata(rd3),
    .hreadyout(ro[3]), .hresp(rs[3]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [63:0] wd, input int waits, input logic resp, input logic [63:0] rdv);
    xfer_t x;
    exp_t e;
    x = '{wr, a, sz, wd};
    e = '{tag, waits, resp, !wr && !resp, rdv};
    pend.push_back(x);
    sb.push_back(e);
  endtask

  // pipelined manager: next address phase overlaps the current data phase
  task automatic run();
    xfer_t dp;
    exp_t e;
    bit have = 0, rdy;
    int waits = 0, cyc = 0;
    logic lowresp = 0;
    while ((pend.size() > 0 || have) && cyc < 300) begin
      cyc++;
      sel = pend.size() > 0;
      htrans = sel ? 2'b10 : 2'b00;
      if (sel) begin
        haddr = pend[0].addr;
        hwrite = pend[0].wr;
        hsize = pend[0].size;
      end
      hw = have ? dp.wdata : 64'h0;
      @(negedge clk);
      rdy = hready;
      if (have && !rdy) begin
        waits++;
        lowresp |= rs[cur];
      end
      if (have && rdy) begin
        e = sb.pop_front();
        chk({e.tag, " waits"}, 64'(waits), 64'(e.waits));
        chk({e.tag, " hresp"}, 64'(rs[cur]), 64'(e.resp));
        chk({e.tag, " wait-hresp"}, 64'(lowresp), 64'(e.resp));
        if (e.rdchk) chk({e.tag, " hrdata"}, rd_cur, e.rdata);
        waits = 0;
        lowresp = 0;
      end
      @(posedge clk);
      #1;
      if (rdy) begin
        have = pend.size() > 0;
        if (have) dp = pend.pop_front();
      end
    end
    if (pend.size() > 0 || have) begin
      ncmp++;
      nfail++;
      $error("FAIL run timeout: %0d transfers outstanding, required 0", pend.size() + int'(have));
      pend.delete();
      sb.delete();
    end
    sel = 0;
    htrans = 0;
    hw = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset d%0d hreadyout", i), 64'(ro[i]), 64'd1);
      chk($sformatf("reset d%0d hresp", i), 64'(rs[i]), 64'd0);
    end
    chk("reset hrdata d0", 64'(rd0), 64'd0);
    chk("reset hrdata d2", rd2, 64'd0);
    @(posedge clk);
    #1;
    cur = 0;
    issue("d0 wr10", 1, 32'h10, 3'd2, 64'hDEADBEEF, 0, 0, 0);
    issue("d0 rd10", 0, 32'h10, 3'd2, 64'h0, 0, 0, 64'hDEADBEEF);
    run();
    issue("d0 wr10b", 1, 32'h10, 3'd2, 64'h11223344, 0, 0, 0);
    issue("d0 byte13", 1, 32'h13, 3'd0, 64'hAA000000, 0, 0, 0);
    issue("d0 rd byte", 0, 32'h10, 3'd2, 64'h0, 0, 0, 64'hAA223344);
    issue("d0 half10", 1, 32'h10, 3'd1, 64'h00005566, 0, 0, 0);
    issue("d0 rd half", 0, 32'h12, 3'd1, 64'h0, 0, 0, 64'hAA225566);
    run();
    issue("d0 wr0", 1, 32'h0, 3'd2, 64'h0BADF00D, 0, 0, 0);
    issue("d0 oor wr", 1, 32'h1000, 3'd2, 64'hFFFFFFFF, 1, 1, 0);
    issue("d0 rd0 a", 0, 32'h0, 3'd2, 64'h0, 0, 0, 64'h0BADF00D);
    issue("d0 unal half", 1, 32'h1, 3'd1, 64'hFFFFFFFF, 1, 1, 0);
    issue("d0 rd0 b", 0, 32'h0, 3'd2, 64'h0, 0, 0, 64'h0BADF00D);
    issue("d0 big size", 0, 32'h0, 3'd3, 64'h0, 1, 1, 0);
    run();
    cur = 1;
    issue("d1 wr1004", 1, 32'h1004, 3'd2, 64'hCAFEF00D, 3, 0, 0);
    issue("d1 rd1004 a", 0, 32'h1004, 3'd2, 64'h0, 3, 0, 64'hCAFEF00D);
    issue("d1 rd1004 b", 0, 32'h1004, 3'd2, 64'h0, 3, 0, 64'hCAFEF00D);
    issue("d1 wr last", 1, 32'h1FFC, 3'd2, 64'h5A5AA5A5, 3, 0, 0);
    issue("d1 rd last", 0, 32'h1FFC, 3'd2, 64'h0, 3, 0, 64'h5A5AA5A5);
    issue("d1 below base", 0, 32'h0FFC, 3'd2, 64'h0, 1, 1, 0);
    issue("d1 above top", 0, 32'h2000, 3'd2, 64'h0, 1, 1, 0);
    run();
    cur = 2;
    issue("d2 wr8", 1, 32'h8, 3'd3, 64'h0123456789ABCDEF, 0, 0, 0);
    issue("d2 rd8", 0, 32'h8, 3'd3, 64'h0, 0, 0, 64'h0123456789ABCDEF);
    issue("d2 wrC word", 1, 32'hC, 3'd2, 64'hFFEEDDCC_00000000, 0, 0, 0);
    issue("d2 rd8 b", 0, 32'h8, 3'd3, 64'h0, 0, 0, 64'hFFEEDDCC89ABCDEF);
    issue("d2 byteF", 1, 32'hF, 3'd0, 64'h11000000_00000000, 0, 0, 0);
    issue("d2 rd8 c", 0, 32'h8, 3'd2, 64'h0, 0, 0, 64'h11EEDDCC89ABCDEF);
    issue("d2 hsize4", 0, 32'h8, 3'd4, 64'h0, 1, 1, 0);
    issue("d2 unal dword", 1, 32'h4, 3'd3, 64'h0, 1, 1, 0);
    issue("d2 rd8 d", 0, 32'h8, 3'd3, 64'h0, 0, 0, 64'h11EEDDCC89ABCDEF);
    run();
    cur = 3;
    issue("d3 wr20", 1, 32'h20, 3'd2, 64'h11111111, 2, 0, 0);
    run();
    sel = 1;
    htrans = 2'b10;
    haddr = 32'h20;
    hwrite = 1;
    hsize = 3'd2;
    @(posedge clk);
    #1;
    sel = 0;
    htrans = 0;
    hw = 64'h22222222;
    @(negedge clk);
    chk("d3 wait hreadyout", 64'(ro[3]), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("d3 completing hreadyout", 64'(ro[3]), 64'd1);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("d3 post-rst hreadyout", 64'(ro[3]), 64'd1);
    chk("d3 post-rst hresp", 64'(rs[3]), 64'd0);
    chk("d3 post-rst hrdata", 64'(rd3), 64'd0);
    @(posedge clk);
    #1;
    hw = 0;
    issue("d3 rd20 kept", 0, 32'h20, 3'd2, 64'h0, 2, 0, 64'h11111111);
    run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/ahb_mem_ws.md
Name: ahb_mem_ws

Overview:
- Parametrised AHB-Lite subordinate memory. Successor to the fixed 32-bit, zero-wait memory used in the Renode co-simulation benches.
- Adds configurable data width, depth, base address and wait states.
- Adds byte/halfword sub-word writes and a two-cycle ERROR response for illegal accesses.
- Sits behind a renode_ahb_manager, with hsel tied high or driven by an interconnect.

Parameters:
- AddressWidth, 32, haddr width.
- DataWidth, 32, hwdata/hrdata width; legal values 32 or 64.
- DepthWords, 1024, number of DataWidth-bit words; must be a power of two.
- BaseAddress, 0, byte address of word 0; must be aligned to DepthWords*DataWidth/8.
- WaitStates, 0, extra cycles with hreadyout low before each OKAY data phase completes; range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- hsel  in  1  subordinate select
- haddr  in  AddressWidth  byte address
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size, log2 bytes
- hburst  in  3  burst type; ignored, each beat is handled independently
- hwdata  in  DataWidth  write data, valid in the data phase
- hready  in  1  bus-level ready
- hrdata  out  DataWidth  read data
- hreadyout  out  1  subordinate ready
- hresp  out  1  0 = OKAY, 1 = ERROR

Behaviour:
- One clock (clk); synchronous, active-high reset rst.
- Reset: hreadyout=1, hresp=0, hrdata=0, FSM to IDLE, wait counter cleared, any pending write dropped. Memory contents are NOT cleared.
- Address phase accepted when hsel && hready && htrans[1] is true at a clk edge. The block registers haddr, hwrite, hsize and the error check.
- IDLE or BUSY with hsel: zero-wait OKAY, no access.
- Error check. A transfer is illegal when any of these holds:
  - address outside [BaseAddress, BaseAddress+DepthWords*DataWidth/8);
  - hsize > log2(DataWidth/8);
  - haddr not aligned to 2^hsize.
- FSM states:
  - IDLE: hreadyout=1, hresp=0. Accepted legal transfer -> ACCESS, counter=WaitStates. Accepted illegal transfer -> ERR1.
  - ACCESS: hreadyout=(counter==0), hresp=0. While counter>0 it decrements each cycle. When counter==0 the data phase completes that cycle:
    - writes commit at that edge;
    - next state is ACCESS or ERR1 if a new transfer is accepted at the same edge (pipelined), otherwise IDLE.
  - ERR1: hreadyout=0, hresp=1, no memory access -> ERR2.
  - ERR2: hreadyout=1, hresp=1. New transfers may be accepted here, with the same transitions as IDLE.
- Write byte lanes:
  - Lanes selected by hsize and haddr[log2(DataWidth/8)-1:0].
  - Only the selected bytes of hwdata update the word; other bytes are unchanged.
  - The write uses the hwdata value present in the completing cycle.
- Read:
  - hrdata = full word at the registered word index, valid in the completing data-phase cycle.
  - hrdata = 0 in IDLE, ERR1 and ERR2.
  - Sub-word reads return the whole word; the manager selects the lanes.
- Read-after-write to the same word in back-to-back transfers returns the new data. The write commits at the edge that starts the read's data phase, and the read indexes the array combinationally.
- Word index = (haddr - BaseAddress) >> log2(DataWidth/8), truncated to log2(DepthWords) bits.
- Reset asserted mid data phase or mid ERROR: the transfer is abandoned. No partial write; outputs return to reset values the next cycle.
- hready low from another subordinate in the IDLE state: no transfer is sampled.

Decomposition:
- Package ahb_mem_pkg:
  - htrans_e (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - hsize_e;
  - state_e (IDLE, ACCESS, ERR1, ERR2);
  - constant HRESP_OKAY=0, HRESP_ERROR=1;
  - function byte_enable(hsize, addr_lsbs, bytes) returning a strobe vector.
- Sub-module ahb_mem_array: DepthWords x DataWidth storage with per-byte write enable and asynchronous read port.

Test Plan:
- DataWidth=32, WaitStates=0: write 0xDEADBEEF to 0x10, read 0x10 -> hrdata=0xDEADBEEF, hreadyout never low, hresp=0.
- Byte write 0xAA at 0x13 (hsize=0, hwdata=0xAA000000) over 0x11223344 at 0x10 -> read returns 0xAA223344. Halfword 0x5566 at 0x10 (hwdata=0x00005566) -> read returns 0xAA225566.
- WaitStates=3: single read -> hreadyout low for exactly 3 cycles, then high with valid data. Back-to-back NONSEQ reads -> each data phase lasts 4 cycles.
- Out-of-range write to BaseAddress+DepthWords*4 -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). A following read of word 0 is unchanged. Unaligned halfword at 0x01 gives the same ERR1/ERR2 sequence.
- DataWidth=64: write 64-bit 0x0123456789ABCDEF to 0x8; a pipelined read of 0x8 in the next address phase returns the new value. hsize=4 at 0x8 -> ERROR.
- rst asserted during a WaitStates=2 write data phase -> hreadyout=1, hresp=0 the next cycle; word retains its old value.
